// File: rtl/alu_cmd_requester.sv
// Command FIFO plus start/ready handshake initiator for the sequential ALU.
// Issues queued operations one at a time and returns each result (or a timeout) downstream.
module alu_cmd_requester #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_sel,
  output logic             rsp_err,
  output logic             busy,
  output logic [7:0]       err_count
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CMD_W = 2 * WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state, state_d;
  logic [CMD_W-1:0] mem [DEPTH];
  logic [CMD_W-1:0] head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  logic             ready_q;
  logic [TMO_W-1:0] tmo, tmo_d;
  logic [WIDTH-1:0] alu_a_d, alu_b_d, rsp_data_d;
  logic [1:0]       alu_sel_d, rsp_sel_d;
  logic             alu_start_d, rsp_valid_d, rsp_err_d, busy_d;
  logic [7:0]       err_count_d;

  // Acceptance depends only on registered occupancy; a full FIFO refuses even on a same-cycle pop.
  assign cmd_ready = (count != CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_sel, cmd_b, cmd_a};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ready_q   <= 1'b0;
      tmo       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      alu_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_sel   <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_d;
      ready_q   <= alu_ready;
      tmo       <= tmo_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_sel   <= alu_sel_d;
      alu_start <= alu_start_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_sel   <= rsp_sel_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
      err_count <= err_count_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    tmo_d       = tmo;
    alu_a_d     = alu_a;
    alu_b_d     = alu_b;
    alu_sel_d   = alu_sel;
    alu_start_d = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_sel_d   = rsp_sel;
    rsp_err_d   = rsp_err;
    err_count_d = err_count;
    busy_d      = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop                            = 1'b1;
          {alu_sel_d, alu_b_d, alu_a_d}  = head;
          alu_start_d                    = 1'b1;
          state_d                        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion edge on the final count takes priority over the timeout.
        if (alu_ready && !ready_q) begin
          rsp_data_d  = alu_result;
          rsp_sel_d   = alu_sel;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_sel_d   = alu_sel;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          if (err_count != 8'hFF) err_count_d = err_count + 8'd1;
          state_d     = S_RESP;
        end else begin
          tmo_d = tmo + TMO_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end
endmodule

// File: tb/tb_alu_cmd_requester.sv
// Randomized scoreboard bench for alu_cmd_requester with a mock sequential ALU
// (level-held or single-pulse ready, optional never-ready commands).
module tb_alu_cmd_requester;
  localparam int unsigned WIDTH   = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [WIDTH-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_data;
  logic [1:0]       cmd_sel, alu_sel, rsp_sel;
  logic             alu_start, alu_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [7:0]       err_count;

  alu_cmd_requester #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_start(alu_start),
    .alu_result(alu_result), .alu_ready(alu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_sel(rsp_sel), .rsp_err(rsp_err),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a, b;
    logic [1:0] sel;
    bit         drop;
  } cmd_t;

  typedef struct {
    logic [3:0] a, b, data;
    logic [1:0] sel;
    logic       err;
    int         lat;
    int         start_cyc;
  } exp_t;

  cmd_t cmd_q[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   outstanding = 0;
  int   model_err = 0;
  int   refused = 0;
  int   mode = 0;
  bit   rand_rdy = 1'b0;
  bit   force_rdy = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    case (sel)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Mock ALU: latches operands on start, raises ready after 3 (level) or 2 (pulse) cycles.
  logic [3:0] m_a, m_b;
  logic [1:0] m_sel;
  bit         m_armed, m_prev_start;
  int         m_cd;
  cmd_t       m_c;
  exp_t       m_e;
  initial begin
    alu_ready = 1'b0; alu_result = '0; m_armed = 0; m_prev_start = 0; m_cd = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        alu_ready = 1'b0; m_armed = 0; m_prev_start = 0; m_cd = 0;
      end else begin
        if (alu_ready && mode == 1) alu_ready = 1'b0;
        if (alu_start) begin
          chk(!m_prev_start, "start_pulse_width", 32'(m_prev_start), 32'd0);
          alu_ready = 1'b0;
          chk(cmd_q.size() > 0, "start_has_cmd", 32'(cmd_q.size()), 32'd1);
          if (cmd_q.size() > 0) begin
            m_c = cmd_q.pop_front();
            chk({alu_sel, alu_b, alu_a} == {m_c.sel, m_c.b, m_c.a}, "start_operands",
                32'({alu_sel, alu_b, alu_a}), 32'({m_c.sel, m_c.b, m_c.a}));
            chk(outstanding == 0, "one_outstanding", 32'(outstanding), 32'd0);
            outstanding++;
            m_e.a = m_c.a; m_e.b = m_c.b; m_e.sel = m_c.sel; m_e.err = m_c.drop;
            m_e.data = m_c.drop ? 4'd0 : ref_alu(m_c.a, m_c.b, m_c.sel);
            m_e.lat = m_c.drop ? int'(TIMEOUT) + 1 : (mode == 1 ? 3 : 4);
            m_e.start_cyc = cyc;
            exp_q.push_back(m_e);
            m_a = alu_a; m_b = alu_b; m_sel = alu_sel;
            m_armed = !m_c.drop;
            m_cd = (mode == 1) ? 2 : 3;
          end
        end else if (m_armed) begin
          m_cd--;
          if (m_cd == 0) begin
            alu_result = ref_alu(m_a, m_b, m_sel);
            alu_ready  = 1'b1;
            m_armed    = 0;
          end
        end
        m_prev_start = alu_start;
      end
    end
  end

  // Downstream ready: forced level or random.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
    end
  end

  // Response monitor: compares against the head of the expected queue every valid cycle.
  bit   in_rsp = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      in_rsp = 0;
    end else if (rsp_valid) begin
      chk(exp_q.size() > 0, "rsp_expected", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q[0];
        if (!in_rsp) begin
          in_rsp = 1;
          chk(cyc - mon_e.start_cyc == mon_e.lat, "rsp_latency",
              32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
          if (mon_e.err && model_err < 255) model_err++;
          chk(err_count == 8'(model_err), "err_count", 32'(err_count), 32'(model_err));
        end
        chk({rsp_data, rsp_sel, rsp_err} == {mon_e.data, mon_e.sel, mon_e.err}, "rsp_payload",
            32'({rsp_data, rsp_sel, rsp_err}), 32'({mon_e.data, mon_e.sel, mon_e.err}));
        chk({alu_sel, alu_b, alu_a} == {mon_e.sel, mon_e.b, mon_e.a}, "alu_operand_hold",
            32'({alu_sel, alu_b, alu_a}), 32'({mon_e.sel, mon_e.b, mon_e.a}));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          in_rsp = 0;
          outstanding--;
        end
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel, input bit drop);
    cmd_t c;
    bit   ok, done;
    done = 0;
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1;
      if (ok) begin
        c.a = a; c.b = b; c.sel = sel; c.drop = drop;
        cmd_q.push_back(c);
        done = 1;
      end else begin
        refused++;
      end
    end
    cmd_valid = 1'b0;
    chk(done, "push_accepted", 32'(done), 32'd1);
  endtask

  task automatic drain(input int max);
    bit done;
    done = 0;
    for (int i = 0; i < max && !done; i++) begin
      @(posedge clk); #1;
      done = (cmd_q.size() == 0) && (exp_q.size() == 0) && (outstanding == 0);
    end
    chk(done, "drain", 32'(exp_q.size() + cmd_q.size()), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({alu_start, rsp_valid, rsp_err, busy} == 4'b0000, {tag, "_ctrl"},
        32'({alu_start, rsp_valid, rsp_err, busy}), 32'd0);
    chk({alu_a, alu_b, alu_sel} == 10'd0, {tag, "_alu_bus"}, 32'({alu_a, alu_b, alu_sel}), 32'd0);
    chk({rsp_data, rsp_sel} == 6'd0, {tag, "_rsp_bus"}, 32'({rsp_data, rsp_sel}), 32'd0);
    chk(err_count == 8'd0, {tag, "_err_count"}, 32'(err_count), 32'd0);
    chk(cmd_ready == 1'b1, {tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0;
    repeat (2) @(posedge clk); #1;
    chk_reset("reset");
    rst = 1'b1;

    // Single add with level-held ready
    push(4'd5, 4'd3, 2'b00, 0);
    drain(200);

    // Response back-pressure: held response, second command must wait
    force_rdy = 1'b0;
    push(4'b1010, 4'b1100, 2'b11, 0);
    push(4'd2, 4'd2, 2'b00, 0);
    for (int i = 0; i < 100 && !rsp_valid; i++) begin @(posedge clk); #1; end
    repeat (5) begin @(posedge clk); #1; end
    chk(rsp_valid && rsp_data == 4'b0110, "held_rsp", 32'({rsp_valid, rsp_data}), 32'h16);
    force_rdy = 1'b1;
    drain(300);

    // Burst past FIFO depth, including a wrapping add
    refused = 0;
    push(4'd15, 4'd1, 2'b00, 0);
    push(4'd7, 4'd2, 2'b01, 0);
    push(4'd12, 4'd10, 2'b10, 0);
    push(4'd9, 4'd6, 2'b11, 0);
    push(4'd3, 4'd4, 2'b00, 0);
    push(4'd0, 4'd1, 2'b01, 0);
    chk(refused > 0, "fifo_full_refusal", 32'(refused), 32'd1);
    drain(500);

    // Timeout followed by a normal command
    push(4'd6, 4'd1, 2'b00, 1);
    push(4'd4, 4'd4, 2'b00, 0);
    drain(300);
    chk(err_count == 8'd1, "err_count_after_timeout", 32'(err_count), 32'd1);

    // Pulsed ready, then random traffic in both ready styles with random back-pressure
    mode = 1;
    for (int i = 0; i < 8; i++) push(4'($urandom), 4'($urandom), 2'($urandom), 0);
    drain(500);
    for (int m = 0; m < 2; m++) begin
      mode = m;
      rand_rdy = 1'b1;
      for (int i = 0; i < 12; i++) begin
        push(4'($urandom), 4'($urandom), 2'($urandom), 0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      drain(1000);
      rand_rdy = 1'b0;
    end

    // Reset during WAIT with two commands queued
    mode = 0;
    push(4'd1, 4'd1, 2'b00, 1);
    push(4'd2, 4'd2, 2'b01, 0);
    push(4'd3, 4'd3, 2'b10, 0);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_reset("mid_reset");
    cmd_q.delete(); exp_q.delete(); outstanding = 0; model_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) begin @(posedge clk); #1; end
    chk(busy == 1'b0 && cmd_ready == 1'b1, "post_reset_idle", 32'({busy, cmd_ready}), 32'b01);
    push(4'd9, 4'd4, 2'b01, 0);
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
